// File: rtl/inst_fifo.sv
// Dual-port instruction buffer between fetch and decode: up to two pushes and two pops per
// cycle, show-ahead read ports, and a one-cycle flush on a taken branch.
module inst_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_rst,
    input  logic        write_en1,
    input  logic        write_en2,
    input  logic [31:0] write_inst1,
    input  logic [31:0] write_inst2,
    input  logic [31:0] write_addr1,
    input  logic [31:0] write_addr2,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic [31:0] read_inst1,
    output logic [31:0] read_inst2,
    output logic [31:0] read_addr1,
    output logic [31:0] read_addr2,
    output logic        read_valid1,
    output logic        read_valid2,
    output logic        empty,
    output logic        fifo_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [63:0]   mem_q [DEPTH];

    logic [1:0]    w_req, w_acc, r_req, r_acc;
    logic [AW:0]   free;
    logic [AW-1:0] head_p1, tail_p1;

    // Slot 2 of either port only counts when slot 1 is also requested.
    assign w_req = 2'(write_en1) + 2'(write_en1 & write_en2);
    assign r_req = 2'(read_en1) + 2'(read_en1 & read_en2);
    assign free  = DEPTH_C - count_q;

    assign head_p1 = head_q + 1'b1;
    assign tail_p1 = tail_q + 1'b1;

    always_comb begin
        w_acc   = w_req;
        r_acc   = r_req;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if ((AW + 1)'(w_req) > free) begin
            w_acc = free[1:0];
        end
        // Acceptance is judged against the count at the start of the cycle, so a
        // same-cycle push never makes an entry readable.
        if ((AW + 1)'(r_req) > count_q) begin
            r_acc = count_q[1:0];
        end
        if (fifo_rst) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(r_acc);
            tail_d  = tail_q + AW'(w_acc);
            count_d = count_q + (AW + 1)'(w_acc) - (AW + 1)'(r_acc);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide what is visible.
    always_ff @(posedge clk) begin
        if (!fifo_rst && w_acc != 2'd0) begin
            mem_q[tail_q] <= {write_inst1, write_addr1};
        end
        if (!fifo_rst && w_acc == 2'd2) begin
            mem_q[tail_p1] <= {write_inst2, write_addr2};
        end
    end

    assign read_valid1 = (count_q != '0);
    assign read_valid2 = (count_q >= (AW + 1)'(2));
    assign empty       = (count_q == '0);
    assign fifo_full   = (count_q >= DEPTH_C - 1'b1);

    assign read_inst1 = read_valid1 ? mem_q[head_q][63:32]  : 32'd0;
    assign read_addr1 = read_valid1 ? mem_q[head_q][31:0]   : 32'd0;
    assign read_inst2 = read_valid2 ? mem_q[head_p1][63:32] : 32'd0;
    assign read_addr2 = read_valid2 ? mem_q[head_p1][31:0]  : 32'd0;

endmodule
